// File: rtl/fbs_ctrl.sv
// fbs_ctrl: sequences fbs backup/restore pulses for the register-frame stack.
// A call produces a single backup pulse. A return produces a restore pulse,
// waits out the frame-cache read latency, then pulses a register-file load.
// The pipeline is stalled throughout. The block also tracks the stack depth
// and keeps sticky overflow/underflow flags.
// Optional feature: define FBS_CTRL_STATS_EN to enable the hw_mark high-water
// register. When the macro is undefined, hw_mark is tied to zero.
module fbs_ctrl #(
  parameter int DEPTH_W   = 16,
  parameter int MAX_DEPTH = 1024,
  parameter int RD_LAT    = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               call_req,
  input  logic               ret_req,
  output logic               fbs_backup,
  output logic               fbs_restore,
  output logic               rf_load,
  output logic               stall,
  output logic [DEPTH_W-1:0] depth,
  output logic               ovf_err,
  output logic               unf_err,
  output logic [DEPTH_W-1:0] hw_mark
);

  // The wait counter must be wide enough to hold RD_LAT.
  localparam int WAIT_W = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);
  localparam logic [DEPTH_W-1:0] MAX_D    = DEPTH_W'(MAX_DEPTH);
  localparam logic [WAIT_W-1:0]  LAT_INIT = WAIT_W'(RD_LAT);
  localparam logic [WAIT_W-1:0]  WAIT_ONE = WAIT_W'(1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BACKUP  = 3'd1,
    RESTORE = 3'd2,
    RWAIT   = 3'd3,
    LOAD    = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic               backup_q, restore_q, load_q, stall_q;

  // Next-state logic.
  // Requests are looked at only in IDLE, and a call takes priority over a return.
  // The depth changes on the edge that leaves BACKUP or RESTORE.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    case (state_q)
      IDLE: begin
        if (call_req) begin
          if (depth_q == MAX_D) begin
            ovf_d = 1'b1;
          end else begin
            state_d = BACKUP;
          end
        end else if (ret_req) begin
          if (depth_q == '0) begin
            unf_d = 1'b1;
          end else begin
            state_d = RESTORE;
          end
        end
      end
      BACKUP: begin
        depth_d = depth_q + DEPTH_W'(1);
        state_d = IDLE;
      end
      RESTORE: begin
        depth_d = depth_q - DEPTH_W'(1);
        wait_d  = LAT_INIT;
        state_d = RWAIT;
      end
      RWAIT: begin
        // Dwell here for RD_LAT cycles. The counter starts at RD_LAT and
        // leaves on the cycle it reads 1.
        wait_d = wait_q - WAIT_ONE;
        if (wait_q == WAIT_ONE) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  // Each output is decoded from the next state, so a pulse appears in the
  // same cycle as the state that owns it, and no request can reach an
  // output without passing through a register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      wait_q    <= '0;
      depth_q   <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      backup_q  <= 1'b0;
      restore_q <= 1'b0;
      load_q    <= 1'b0;
      stall_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      depth_q   <= depth_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      backup_q  <= (state_d == BACKUP);
      restore_q <= (state_d == RESTORE);
      load_q    <= (state_d == LOAD);
      stall_q   <= (state_d != IDLE);
    end
  end

  assign fbs_backup  = backup_q;
  assign fbs_restore = restore_q;
  assign rf_load     = load_q;
  assign stall       = stall_q;
  assign depth       = depth_q;
  assign ovf_err     = ovf_q;
  assign unf_err     = unf_q;

`ifdef FBS_CTRL_STATS_EN
  logic [DEPTH_W-1:0] hw_q, hw_d;

  // High-water mark. It is updated on the same edge that commits a backup's
  // depth increment.
  always_comb begin
    hw_d = hw_q;
    if ((state_q == BACKUP) && (depth_d > hw_q)) begin
      hw_d = depth_d;
    end
  end

  // High-water register.
  always_ff @(posedge clk) begin
    if (reset) begin
      hw_q <= '0;
    end else begin
      hw_q <= hw_d;
    end
  end

  assign hw_mark = hw_q;
`else
  assign hw_mark = '0;
`endif

endmodule

// File: tb/tb_fbs_ctrl.sv
// Testbench for fbs_ctrl.
// Random call/return traffic drives a stack model. The model posts the
// expected pulses (kind, cycle, depth) to a scoreboard. A negedge monitor
// pops and compares them whenever the DUT shows a pulse or an error edge.
module tb_fbs_ctrl;
  localparam int DW   = 16;
  localparam int MAXD = 4;
  localparam int RDL  = 2;

  logic          clk = 1'b0;
  logic          reset, call_req, ret_req;
  logic          fbs_backup, fbs_restore, rf_load, stall, ovf_err, unf_err;
  logic [DW-1:0] depth, hw_mark;

  fbs_ctrl #(.DEPTH_W(DW), .MAX_DEPTH(MAXD), .RD_LAT(RDL)) dut (
    .clk(clk), .reset(reset), .call_req(call_req), .ret_req(ret_req),
    .fbs_backup(fbs_backup), .fbs_restore(fbs_restore), .rf_load(rf_load),
    .stall(stall), .depth(depth), .ovf_err(ovf_err), .unf_err(unf_err),
    .hw_mark(hw_mark)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int kind;   // 0 backup, 1 restore, 2 load, 3 ovf, 4 unf
    int at;
    int dep;
  } ev_t;

  ev_t sb[$];
  bit  exp_stall [0:8191];
  bit  mon_en = 1'b0;
  int  total = 0, bad = 0;

  // Reference model state.
  int m_depth, m_hw, idle_at;
  bit m_ovf, m_unf;

  string knames [0:4] = '{"backup", "restore", "load", "ovf", "unf"};

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic take(input int kind);
    ev_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_%s: got event want none (cycle %0d)", knames[kind], cyc);
    end else begin
      e = sb.pop_front();
      $display("cycle %0d: %s depth=%0d", cyc, knames[kind], depth);
      check("ev_kind", kind, e.kind);
      check("ev_cycle", cyc, e.at);
      check("ev_depth", depth, e.dep);
    end
  endtask

  // Monitor: checks stall every cycle and matches each pulse or error edge
  // against the scoreboard.
  logic ovf_prev = 1'b0, unf_prev = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      check("stall", stall, exp_stall[cyc]);
      if (fbs_backup)            take(0);
      if (fbs_restore)           take(1);
      if (rf_load)               take(2);
      if (ovf_err && !ovf_prev)  take(3);
      if (unf_err && !unf_prev)  take(4);
    end
    ovf_prev = ovf_err;
    unf_prev = unf_err;
  end

  task automatic model_reset();
    m_depth = 0;
    m_hw    = 0;
    m_ovf   = 0;
    m_unf   = 0;
    idle_at = cyc;
  endtask

  // Drive one cycle of requests. The model decides what the requests should
  // cause. Requests made while the DUT is busy are expected to be ignored.
  task automatic do_cycle(input bit c, input bit r);
    if (cyc >= idle_at) begin
      if (c) begin
        if (m_depth < MAXD) begin
          sb.push_back('{0, cyc + 1, m_depth});
          exp_stall[cyc + 1] = 1'b1;
          m_depth++;
          if (m_depth > m_hw) m_hw = m_depth;
          idle_at = cyc + 2;
        end else begin
          if (!m_ovf) sb.push_back('{3, cyc + 1, m_depth});
          m_ovf = 1'b1;
        end
      end else if (r) begin
        if (m_depth > 0) begin
          sb.push_back('{1, cyc + 1, m_depth});
          sb.push_back('{2, cyc + RDL + 2, m_depth - 1});
          for (int k = 1; k <= RDL + 2; k++) exp_stall[cyc + k] = 1'b1;
          m_depth--;
          idle_at = cyc + RDL + 3;
        end else begin
          if (!m_unf) sb.push_back('{4, cyc + 1, m_depth});
          m_unf = 1'b1;
        end
      end
    end
    call_req = c;
    ret_req  = r;
    @(posedge clk);
    #1;
    call_req = 1'b0;
    ret_req  = 1'b0;
  endtask

  task automatic wait_idle();
    while (cyc < idle_at) do_cycle(1'b0, 1'b0);
    repeat (2) do_cycle(1'b0, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_backup"}, fbs_backup, 0);
    check({tag, "_restore"}, fbs_restore, 0);
    check({tag, "_load"}, rf_load, 0);
    check({tag, "_stall"}, stall, 0);
    check({tag, "_depth"}, depth, 0);
    check({tag, "_ovf"}, ovf_err, 0);
    check({tag, "_unf"}, unf_err, 0);
    check({tag, "_hw"}, hw_mark, 0);
  endtask

  task automatic check_final(input string tag);
    int exp_hw;
`ifdef FBS_CTRL_STATS_EN
    exp_hw = m_hw;
`else
    exp_hw = 0;
`endif
    check({tag, "_sb_empty"}, sb.size(), 0);
    check({tag, "_depth"}, depth, m_depth);
    check({tag, "_ovf"}, ovf_err, m_ovf);
    check({tag, "_unf"}, unf_err, m_unf);
    check({tag, "_hw"}, hw_mark, exp_hw);
  endtask

  initial begin
    int sel;
    reset    = 1'b1;
    call_req = 1'b0;
    ret_req  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_zero("reset");
    model_reset();
    mon_en = 1'b1;

    // Directed start: a return at depth 0 underflows, then a simultaneous
    // call and return lets the call win.
    do_cycle(1'b0, 1'b1);
    do_cycle(1'b1, 1'b1);
    wait_idle();

    // Random traffic, including requests that land while the DUT is busy.
    for (int i = 0; i < 500; i++) begin
      sel = $urandom_range(0, 9);
      if (cyc >= idle_at) begin
        if (sel < 4)       do_cycle(1'b1, 1'b0);
        else if (sel < 7)  do_cycle(1'b0, 1'b1);
        else if (sel == 7) do_cycle(1'b1, 1'b1);
        else               do_cycle(1'b0, 1'b0);
      end else begin
        do_cycle(sel == 0, sel == 1);
      end
    end
    wait_idle();
    check_final("random");

    // Reset asserted while the DUT sits in RWAIT.
    mon_en = 1'b0;
    do_cycle(1'b1, 1'b0);
    wait_idle();
    do_cycle(1'b0, 1'b1);  // return sampled here, restore in the next cycle
    do_cycle(1'b0, 1'b0);  // restore cycle
    reset = 1'b1;          // now in RWAIT
    @(posedge clk);
    #1;
    check_zero("rwait_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    model_reset();
    for (int k = 0; k < RDL + 8; k++) exp_stall[cyc + k] = 1'b0;
    repeat (2) do_cycle(1'b0, 1'b0);
    check_zero("post_reset");
    mon_en = 1'b1;

    // Three calls followed by two returns.
    for (int k = 0; k < 3; k++) begin
      do_cycle(1'b1, 1'b0);
      wait_idle();
    end
    for (int k = 0; k < 2; k++) begin
      do_cycle(1'b0, 1'b1);
      wait_idle();
    end
    check_final("stats");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
